// File: rtl/dac_update_sequencer.sv
// dac_update_sequencer
// Holds four 8-bit channel setpoints written over a valid/ready port and
// packs them into the 32-bit word {ch3, ch2, ch1, ch0} for the dual-DAC SPI
// serializer. It issues the serializer's active-low start strobe and keeps the
// word stable for a whole frame. Commits that arrive while a frame is in
// flight are merged into a single follow-up frame.
//
// Optional feature, selected at compile time:
//   DAC_SLEW_EN - each frame moves every channel at most SLEW_STEP codes toward
//                 its target. Frames repeat on their own until all channels
//                 reach their targets.
//                 When DAC_SLEW_EN is not defined, every frame copies the
//                 targets directly.

module dac_update_sequencer #(
   parameter int CS_HOLD     = 64,
   parameter int BUSY_CYCLES = 2400,
   parameter int SLEW_STEP   = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wr_valid,
   output logic        o_wr_ready,
   input  logic [1:0]  i_wr_ch,
   input  logic [7:0]  i_wr_code,
   input  logic        i_commit,
   output logic [31:0] o_data,
   output logic        o_CS,
   output logic        o_busy,
   output logic [15:0] o_frames
);

`ifdef DAC_SLEW_EN
   localparam bit SLEW_EN = 1'b1;
`else
   localparam bit SLEW_EN = 1'b0;
`endif

   // A step of 255 covers every possible 8-bit distance, so the slew path
   // collapses into a plain copy when limiting is compiled out.
   localparam logic [7:0] STEP8 = SLEW_EN ? 8'(SLEW_STEP) : 8'd255;

   // The STROBE and WAIT phases share one down-counter.
   localparam int CNT_MAX = (CS_HOLD > BUSY_CYCLES) ? CS_HOLD : BUSY_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_STROBE,
      S_WAIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             pending;
   logic [7:0]       tgt_code [4];
   logic [7:0]       out_code [4];
   logic [7:0]       nxt_code [4];
   logic             converged;
   logic             wr_fire;

   assign wr_fire = i_wr_valid & o_wr_ready;

   // Code each channel takes on the LOAD edge, and whether every channel then matches its target.
   always_comb begin
      // NOTE: every variable gets a default before any branch so that no path leaves it unassigned, which would infer a latch.
      converged = 1'b1;
      for (int k = 0; k < 4; k++) begin
         nxt_code[k] = tgt_code[k];
         if (tgt_code[k] > out_code[k]) begin
            if (tgt_code[k] - out_code[k] > STEP8) nxt_code[k] = out_code[k] + STEP8;
         end else if (out_code[k] - tgt_code[k] > STEP8) begin
            nxt_code[k] = out_code[k] - STEP8;
         end
         if (nxt_code[k] != tgt_code[k]) converged = 1'b0;
      end
   end

   // Frame sequencer, setpoint registers and all registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         pending    <= 1'b0;
         o_frames   <= '0;
         o_data     <= '0;
         // Reset sets the strobe flop, so o_CS goes high as soon as reset asserts and cannot pulse low.
         o_CS       <= 1'b1;
         o_busy     <= 1'b0;
         o_wr_ready <= 1'b1;
         // NOTE: these eight bytes are small flop arrays that must come out of reset at zero, so they are reset explicitly; a real RAM would not be reset this way.
         for (int k = 0; k < 4; k++) begin
            tgt_code[k] <= '0;
            out_code[k] <= '0;
         end
      end else begin
         // NOTE: state is updated with non-blocking assignments only, so every read in this block sees the value from before the edge.
         if (wr_fire) tgt_code[i_wr_ch] <= i_wr_code;

         o_data <= {out_code[3], out_code[2], out_code[1], out_code[0]};
         o_busy <= (state != S_IDLE);
         o_CS   <= (state != S_STROBE);

         if (i_commit) pending <= 1'b1;

         case (state)
            S_IDLE: begin
               if (pending | i_commit) begin
                  state      <= S_LOAD;
                  o_wr_ready <= 1'b0;
               end
            end
            S_LOAD: begin
               for (int k = 0; k < 4; k++) out_code[k] <= nxt_code[k];
               o_frames   <= o_frames + 16'd1;
               o_wr_ready <= 1'b1;
               cnt        <= CNT_W'(CS_HOLD - 1);
               state      <= S_STROBE;
               // A commit on this same edge wins over the clear. An unconverged slew also requests another frame.
               pending    <= i_commit | ~converged;
            end
            S_STROBE: begin
               if (cnt == '0) begin
                  cnt   <= CNT_W'(BUSY_CYCLES - 1);
                  state <= S_WAIT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_WAIT: begin
               if (cnt == '0) state <= S_IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
